// File: rtl/loc_cam_bien_muc_pkg.sv
// muc_pkg: shared types and safe/reset constants for the level-sensor conditioning stage.
package muc_pkg;
    typedef enum logic [1:0] {INIT, RUN, SUSPECT, FAULT} muc_state_t;
    localparam logic SAFE_HIGH = 1'b1;
    localparam logic SAFE_LOW  = 1'b1;
    localparam logic DB_RST    = 1'b1;
endpackage

// File: rtl/loc_cam_bien_muc_loc_nhieu.sv
// loc_nhieu: 2-flop synchroniser plus counting debouncer for one float-switch channel.
module loc_nhieu
    import muc_pkg::*;
#(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_raw,
    output logic d_db
);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic s1_q, s2_q, db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic diff;

    assign diff  = s2_q != db_q;
    assign db_d  = (diff && cnt_q == LAST) ? s2_q : db_q;
    assign cnt_d = (diff && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
    assign d_db  = db_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q  <= DB_RST;
            s2_q  <= DB_RST;
            db_q  <= DB_RST;
            cnt_q <= '0;
        end else begin
            s1_q  <= d_raw;
            s2_q  <= s1_q;
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/loc_cam_bien_muc.sv
// loc_cam_bien_muc: debounces both tank-level switches, checks plausibility and
// forces the "tank full, pump off" pair during start-up and on sensor fault.
module loc_cam_bien_muc
    import muc_pkg::*;
#(
    parameter int DEB_CYCLES   = 16,
    parameter int FAULT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic high_raw,
    input  logic low_raw,
    output logic high,
    output logic low,
    output logic valid,
    output logic fault
);
    localparam int INIT_LAST = DEB_CYCLES + 1;
    localparam int CMAX      = (FAULT_CYCLES > INIT_LAST) ? FAULT_CYCLES : INIT_LAST;
    localparam int CW        = $clog2(CMAX + 1);

    muc_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic db_high, db_low, bad, run;
    logic high_q, low_q, valid_q, fault_q;

    loc_nhieu #(.DEB_CYCLES(DEB_CYCLES)) u_high (.clk(clk), .rst_n(rst_n), .d_raw(high_raw), .d_db(db_high));
    loc_nhieu #(.DEB_CYCLES(DEB_CYCLES)) u_low  (.clk(clk), .rst_n(rst_n), .d_raw(low_raw),  .d_db(db_low));

    assign bad = db_high & ~db_low;

    // SUSPECT exits one count early so fault rises FAULT_CYCLES after the bad pair
    // appears, counting the RUN->SUSPECT edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                state_d = (cnt_q == CW'(INIT_LAST)) ? RUN : INIT;
                cnt_d   = (cnt_q == CW'(INIT_LAST)) ? '0 : cnt_q + 1'b1;
            end
            RUN: begin
                state_d = bad ? SUSPECT : RUN;
                cnt_d   = '0;
            end
            SUSPECT: begin
                state_d = !bad ? RUN : (cnt_q == CW'(FAULT_CYCLES - 2)) ? FAULT : SUSPECT;
                cnt_d   = (!bad || cnt_q == CW'(FAULT_CYCLES - 2)) ? '0 : cnt_q + 1'b1;
            end
            FAULT: begin
                state_d = (!bad && cnt_q == CW'(FAULT_CYCLES - 1)) ? RUN : FAULT;
                cnt_d   = (bad || cnt_q == CW'(FAULT_CYCLES - 1)) ? '0 : cnt_q + 1'b1;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign run = (state_d == RUN) || (state_d == SUSPECT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q   <= '0;
            high_q  <= SAFE_HIGH;
            low_q   <= SAFE_LOW;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            high_q  <= run ? db_high : SAFE_HIGH;
            low_q   <= run ? db_low : SAFE_LOW;
            valid_q <= run;
            fault_q <= state_d == FAULT;
        end
    end

    assign high  = high_q;
    assign low   = low_q;
    assign valid = valid_q;
    assign fault = fault_q;
endmodule

// File: tb/tb_loc_cam_bien_muc.sv
// tb_loc_cam_bien_muc: directed vectors with a cycle-tagged scoreboard, DEB_CYCLES=4, FAULT_CYCLES=8.
module tb_loc_cam_bien_muc;
    typedef struct {
        int          cyc;
        string       name;
        logic [3:0]  hlvf;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, high_raw = 1'b0, low_raw = 1'b0;
    logic high, low, valid, fault;
    int   cyc = 0, vectors = 0, miscompares = 0;
    exp_t sb[$];
    exp_t e;

    loc_cam_bien_muc #(.DEB_CYCLES(4), .FAULT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .high_raw(high_raw), .low_raw(low_raw),
        .high(high), .low(low), .valid(valid), .fault(fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_at(input int off, input string name, input logic [3:0] hlvf);
        sb.push_back('{cyc + off, name, hlvf});
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares the DUT whenever an expectation falls due on this cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            vectors++;
            if (e.cyc != cyc || {high, low, valid, fault} !== e.hlvf) begin
                miscompares++;
                $display("FAIL %s cyc %0d: got h/l/v/f=%b want %b (due cyc %0d)",
                         e.name, cyc, {high, low, valid, fault}, e.hlvf, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        wait_cycles(1);
        expect_at(0, "rst_hold", 4'b1100);
        wait_cycles(2);
        rst_n = 1'b1;
        expect_at(5, "init_hold", 4'b1100);
        expect_at(6, "init_done", 4'b1110);
        expect_at(7, "run_idle", 4'b0010);
        wait_cycles(10);

        low_raw = 1'b1;
        expect_at(6, "low_before", 4'b0010);
        expect_at(7, "low_rise", 4'b0110);
        wait_cycles(10);

        high_raw = 1'b1;
        expect_at(7, "glitch_a", 4'b0110);
        expect_at(12, "glitch_b", 4'b0110);
        wait_cycles(3);
        high_raw = 1'b0;
        wait_cycles(12);

        high_raw = 1'b1;
        low_raw  = 1'b0;
        expect_at(6, "sus_pre", 4'b0110);
        expect_at(7, "sus_enter", 4'b1010);
        expect_at(13, "sus_hold", 4'b1010);
        expect_at(14, "fault_in", 4'b1101);
        wait_cycles(20);
        low_raw = 1'b1;
        expect_at(13, "fault_hold", 4'b1101);
        expect_at(14, "fault_out", 4'b1110);
        wait_cycles(18);

        low_raw = 1'b0;
        expect_at(6, "blip_pre", 4'b1110);
        expect_at(7, "blip_sus", 4'b1010);
        expect_at(11, "blip_hold", 4'b1010);
        expect_at(12, "blip_back", 4'b1110);
        expect_at(16, "blip_nofault", 4'b1110);
        wait_cycles(5);
        low_raw = 1'b1;
        wait_cycles(15);

        high_raw = 1'b0;
        wait_cycles(3);
        #2 rst_n = 1'b0;
        expect_at(0, "rst_deb", 4'b1100);
        expect_at(1, "rst_deb_hold", 4'b1100);
        wait_cycles(2);
        rst_n = 1'b1;
        expect_at(5, "init2_hold", 4'b1100);
        expect_at(6, "init2_done", 4'b1110);
        expect_at(7, "init2_run", 4'b0110);
        wait_cycles(10);

        high_raw = 1'b1;
        low_raw  = 1'b0;
        expect_at(13, "fault2_pre", 4'b1010);
        expect_at(14, "fault2_in", 4'b1101);
        wait_cycles(16);
        #2 rst_n = 1'b0;
        expect_at(0, "rst_fault", 4'b1100);
        wait_cycles(2);
        rst_n = 1'b1;
        expect_at(5, "init3_hold", 4'b1100);
        expect_at(6, "init3_done", 4'b1110);
        expect_at(7, "init3_sus", 4'b1010);
        expect_at(13, "init3_sus_hold", 4'b1010);
        expect_at(14, "init3_fault", 4'b1101);
        wait_cycles(20);

        if (sb.size() != 0) begin
            miscompares += sb.size();
            $display("FAIL scoreboard: %0d expectations never checked", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
